// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester Avalon round-robin arbiter.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int CNT_W = 8;

    localparam logic [DW-1:0] ERRDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin priority search: first pending index after 'last', wrapping,
// with 'last' itself considered only after the other three.
module rr_pick4 (
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Walk candidates from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        any  = |pending;
        idx  = 2'd0;
        cand = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + k[1:0];
            if (pending[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/avalon_rr_arbiter4.sv
// Four-requester Avalon-MM arbiter onto a single slave: round-robin grant,
// one command at a time, read data returned to the owner or aborted on timeout.
module avalon_rr_arbiter4
    import arb_pkg::*;
#(
    parameter int            TIMEOUT = 255,
    parameter logic [DW-1:0] ERRDATA = ERRDATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      r_write,
    input  logic [NREQ-1:0]      r_read,
    input  logic [NREQ*AW-1:0]   r_address,
    input  logic [NREQ*DW-1:0]   r_writedata,
    output logic [NREQ-1:0]      r_waitrequest,
    output logic [NREQ-1:0]      r_readdatavalid,
    output logic [DW-1:0]        r_readdata,
    output logic                 s_write,
    output logic                 s_read,
    output logic [AW-1:0]        s_address,
    output logic [DW-1:0]        s_writedata,
    input  logic                 s_waitrequest,
    input  logic                 s_readdatavalid,
    input  logic [DW-1:0]        s_readdata,
    output logic [1:0]           grant,
    output logic                 grant_valid,
    output logic                 err_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    arb_state_t       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  pending;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic             g_write, g_read;
    logic [AW-1:0]    g_address;
    logic [DW-1:0]    g_writedata;

    assign pending     = r_write | r_read;
    assign g_write     = r_write[grant_q];
    assign g_read      = r_read[grant_q];
    assign g_address   = r_address[32'(grant_q) * AW +: AW];
    assign g_writedata = r_writedata[32'(grant_q) * DW +: DW];

    rr_pick4 u_pick (
        .pending (pending),
        .last    (last_q),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // State, ownership and timeout bookkeeping; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and all slave/requester-facing outputs.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        s_write         = 1'b0;
        s_read          = 1'b0;
        s_address       = '0;
        s_writedata     = '0;
        r_waitrequest   = pending;
        r_readdatavalid = '0;
        r_readdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_CMD;
                    grant_d = pick_idx;
                end
            end
            ST_CMD: begin
                // A simultaneous write and read from the owner is issued as a write.
                s_write     = g_write;
                s_read      = g_read & ~g_write;
                s_address   = g_address;
                s_writedata = g_writedata;
                if (!g_write && !g_read) begin
                    state_d = ST_IDLE;
                end else if (!s_waitrequest) begin
                    r_waitrequest[grant_q] = 1'b0;
                    if (g_write) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end else begin
                        state_d = ST_RDWAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RDWAIT: begin
                if (s_readdatavalid) begin
                    r_readdatavalid[grant_q] = 1'b1;
                    r_readdata               = s_readdata;
                    state_d                  = ST_IDLE;
                    last_d                   = grant_q;
                end else if (cnt_q == TIMEOUT_C) begin
                    r_readdatavalid[grant_q] = 1'b1;
                    r_readdata               = ERRDATA;
                    err_d                    = 1'b1;
                    state_d                  = ST_IDLE;
                    last_d                   = grant_q;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == ST_CMD) || (state_q == ST_RDWAIT);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_avalon_rr_arbiter4.sv
// Self-checking bench for avalon_rr_arbiter4: directed scenarios with literal
// expectations plus randomized requesters/slave against a transaction-level model.
module tb_avalon_rr_arbiter4;

    localparam int TO = 20;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   r_write = '0;
    logic [3:0]   r_read = '0;
    logic [63:0]  r_address = '0;
    logic [127:0] r_writedata = '0;
    logic [3:0]   r_waitrequest;
    logic [3:0]   r_readdatavalid;
    logic [31:0]  r_readdata;
    logic         s_write, s_read;
    logic [15:0]  s_address;
    logic [31:0]  s_writedata;
    logic         s_waitrequest = 1'b0;
    logic         s_readdatavalid = 1'b0;
    logic [31:0]  s_readdata = '0;
    logic [1:0]   grant;
    logic         grant_valid;
    logic         err_timeout;

    avalon_rr_arbiter4 #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .r_write         (r_write),
        .r_read          (r_read),
        .r_address       (r_address),
        .r_writedata     (r_writedata),
        .r_waitrequest   (r_waitrequest),
        .r_readdatavalid (r_readdatavalid),
        .r_readdata      (r_readdata),
        .s_write         (s_write),
        .s_read          (s_read),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdatavalid (s_readdatavalid),
        .s_readdata      (s_readdata),
        .grant           (grant),
        .grant_valid     (grant_valid),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the slave, and how long its read has waited.
    int m_owner;   // -1 when nobody owns the slave
    int m_age;     // -1 while the command is still being offered, else read-wait cycles so far
    int m_last;
    int m_grant;
    bit m_err;

    logic        e_s_write, e_s_read, e_gv;
    logic [15:0] e_s_addr;
    logic [31:0] e_s_wdata, e_rdata;
    logic [3:0]  e_wr, e_rdv;

    task automatic model_reset();
        m_owner = -1; m_age = -1; m_last = 3; m_grant = 0; m_err = 0;
    endtask

    function automatic bit pend(input int i);
        return r_write[i] | r_read[i];
    endfunction

    task automatic compute_expected();
        e_s_write = 0; e_s_read = 0; e_s_addr = '0; e_s_wdata = '0;
        e_rdv = '0; e_rdata = '0; e_gv = (m_owner >= 0);
        for (int i = 0; i < 4; i++) e_wr[i] = pend(i);
        if (m_owner >= 0 && m_age < 0) begin
            e_s_write = r_write[m_owner];
            e_s_read  = r_read[m_owner] & ~r_write[m_owner];
            e_s_addr  = r_address[m_owner*16 +: 16];
            e_s_wdata = r_writedata[m_owner*32 +: 32];
            if (!s_waitrequest) e_wr[m_owner] = 1'b0;
        end else if (m_owner >= 0) begin
            if (s_readdatavalid) begin
                e_rdv[m_owner] = 1'b1; e_rdata = s_readdata;
            end else if (m_age == TO) begin
                e_rdv[m_owner] = 1'b1; e_rdata = ERRD;
            end
        end
    endtask

    task automatic model_next();
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && pend((m_last + k) % 4)) m_owner = (m_last + k) % 4;
            end
            if (m_owner >= 0) begin m_grant = m_owner; m_age = -1; end
        end else if (m_age < 0) begin
            if (!pend(m_owner)) m_owner = -1;
            else if (!s_waitrequest) begin
                if (r_write[m_owner]) begin m_last = m_owner; m_owner = -1; end
                else m_age = 0;
            end
        end else begin
            if (s_readdatavalid || m_age == TO) begin
                if (!s_readdatavalid) m_err = 1;
                m_last = m_owner; m_owner = -1; m_age = -1;
            end else m_age++;
        end
    endtask

    // Called #1 after inputs settle: compare every output against the model, then move to the next cycle.
    task automatic advance();
        if (rst) model_reset();
        compute_expected();
        check("s_write", 32'(s_write), 32'(e_s_write));
        check("s_read", 32'(s_read), 32'(e_s_read));
        check("s_address", 32'(s_address), 32'(e_s_addr));
        check("s_writedata", s_writedata, e_s_wdata);
        check("r_waitrequest", 32'(r_waitrequest), 32'(e_wr));
        check("r_readdatavalid", 32'(r_readdatavalid), 32'(e_rdv));
        check("r_readdata", r_readdata, e_rdata);
        check("grant_valid", 32'(grant_valid), 32'(e_gv));
        check("grant", 32'(grant), 32'(m_grant));
        check("err_timeout", 32'(err_timeout), 32'(m_err));
        if (!rst) model_next();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1; r_write = '0; r_read = '0; s_waitrequest = 0; s_readdatavalid = 0;
        #1;
        check("rst grant_valid", 32'(grant_valid), 0);
        check("rst grant", 32'(grant), 0);
        check("rst err_timeout", 32'(err_timeout), 0);
        check("rst rdv", 32'(r_readdatavalid), 0);
        advance();
        r_write = 4'b0101;
        #1;
        check("rst waitrequest follows pending", 32'(r_waitrequest), 32'h5);
        check("rst s_write", 32'(s_write), 0);
        advance();
        r_write = '0;
    endtask

    bit          act [4];
    bit          is_wr [4];
    bit          both [4];
    int          lat;
    int          seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        model_reset();
        @(negedge clk);

        // Single write: command appears on the second cycle after release.
        reset_dut();
        rst = 0; r_write = 4'b0001; r_address[15:0] = 16'h0100; r_writedata[31:0] = 32'hA5A5_0001;
        #1; check("c1 s_write", 32'(s_write), 0); advance();
        #1;
        check("c2 s_write", 32'(s_write), 1);
        check("c2 s_writedata", s_writedata, 32'hA5A5_0001);
        check("c2 waitrequest0", 32'(r_waitrequest[0]), 0);
        advance();
        r_write = '0; #1; advance();

        // Four continuous writers: grants 0,1,2,3,0 on every second cycle.
        reset_dut();
        rst = 0; r_write = 4'hF;
        for (int i = 0; i < 4; i++) begin
            r_address[i*16 +: 16] = 16'(16'h2000 + i);
            r_writedata[i*32 +: 32] = 32'hC0DE_0000 + i;
        end
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (c % 2 == 0) begin
                check("rr grant", 32'(grant), 32'(seq[c/2 - 1]));
                check("rr s_write", 32'(s_write), 1);
            end
            advance();
        end
        r_write = '0; #1; advance();

        // Requester 2 reads; slave answers on the third wait cycle.
        reset_dut();
        rst = 0; r_read = 4'b0100; r_address[47:32] = 16'h0010;
        #1; advance();
        #1;
        check("rd s_read", 32'(s_read), 1);
        check("rd s_address", 32'(s_address), 32'h10);
        advance();
        r_read = '0;
        #1; check("rd wait1", 32'(r_readdatavalid), 0); advance();
        #1; check("rd wait2", 32'(r_readdatavalid), 0); advance();
        s_readdatavalid = 1; s_readdata = 32'h1234_5678;
        #1;
        check("rd rdv", 32'(r_readdatavalid), 32'h4);
        check("rd data", r_readdata, 32'h1234_5678);
        advance();
        s_readdatavalid = 0;
        #1;
        check("rd rdv one cycle", 32'(r_readdatavalid), 0);
        check("rd data zero", r_readdata, 0);
        advance();

        // Read never answered: error data after TO+1 wait cycles, sticky flag.
        reset_dut();
        rst = 0; r_read = 4'b0010;
        #1; advance();
        #1; check("to s_read", 32'(s_read), 1); advance();
        r_read = '0;
        for (int k = 1; k <= TO + 1; k++) begin
            #1;
            if (k <= TO) check("to no rdv yet", 32'(r_readdatavalid), 0);
            else begin
                check("to rdv", 32'(r_readdatavalid), 32'h2);
                check("to errdata", r_readdata, ERRD);
                check("to err not yet", 32'(err_timeout), 0);
            end
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            #1; check("to err sticky", 32'(err_timeout), 1); advance();
        end

        // Slave stalls a write for 5 cycles: command and grant hold, only the owner is released.
        reset_dut();
        rst = 0; r_write = 4'b0011; s_waitrequest = 1;
        r_address[15:0] = 16'h0ABC; r_writedata[31:0] = 32'h0000_5555;
        #1; advance();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall s_address", 32'(s_address), 32'h0ABC);
            check("stall grant", 32'(grant), 0);
            check("stall waitrequest", 32'(r_waitrequest), 32'h3);
            advance();
        end
        s_waitrequest = 0;
        #1; check("stall accept waitrequest", 32'(r_waitrequest), 32'h2); advance();
        r_write = 4'b0010;
        #1; advance();
        #1; check("stall next grant", 32'(grant), 1); advance();
        r_write = '0; #1; advance();

        // Reset during a read wait: abandoned, late data ignored.
        reset_dut();
        rst = 0; r_read = 4'b1000; r_address[63:48] = 16'h0033;
        #1; advance();
        #1; advance();
        r_read = '0;
        #1; check("rw grant_valid", 32'(grant_valid), 1); advance();
        rst = 1;
        #1;
        check("rw rst grant_valid", 32'(grant_valid), 0);
        check("rw rst grant", 32'(grant), 0);
        check("rw rst rdv", 32'(r_readdatavalid), 0);
        advance();
        rst = 0; s_readdatavalid = 1; s_readdata = 32'h7777_7777;
        #1;
        check("rw late rdv", 32'(r_readdatavalid), 0);
        check("rw late data", r_readdata, 0);
        advance();
        s_readdatavalid = 0;

        // Randomized traffic against the model.
        reset_dut();
        rst = 0;
        for (int i = 0; i < 4; i++) act[i] = 0;
        lat = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom % 700 == 0);
            for (int i = 0; i < 4; i++) begin
                if (!act[i] && $urandom % 4 == 0) begin
                    act[i] = 1;
                    is_wr[i] = $urandom % 2;
                    both[i] = ($urandom % 8 == 0);
                    r_address[i*16 +: 16] = 16'($urandom);
                    r_writedata[i*32 +: 32] = $urandom;
                end
                r_write[i] = act[i] && (is_wr[i] || both[i]);
                r_read[i]  = act[i] && (!is_wr[i] || both[i]);
            end
            s_waitrequest = ($urandom % 3 == 0);
            s_readdata = $urandom;
            if (m_owner >= 0 && m_age >= 0) s_readdatavalid = (m_age == lat);
            else s_readdatavalid = ($urandom % 8 == 0);
            #1;
            advance();
            for (int i = 0; i < 4; i++) begin
                if (act[i] && !e_wr[i]) act[i] = 0;
                else if (act[i] && $urandom % 40 == 0) act[i] = 0;
            end
            if (m_age < 0) lat = $urandom_range(0, TO + 5);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
